// File: rtl/peak_pair_hasher_if.sv
// Hash stream from the peak pair hasher towards the hash FIFO / HPS bridge.
// The hasher drives the master side; the consumer drives hash_ready.
interface peak_pair_hasher_if #(
  parameter int FREQ_W = 9,
  parameter int TIME_W = 16,
  parameter int DT_W   = 2
);
  logic                     hash_valid;
  logic                     hash_ready;
  logic [2*FREQ_W+DT_W-1:0] hash_data;
  logic [TIME_W-1:0]        hash_time;

  modport master (output hash_valid, output hash_data, output hash_time, input hash_ready);
  modport slave  (input hash_valid, input hash_data, input hash_time, output hash_ready);
endinterface

// File: rtl/peak_pair_hasher.sv
// Pairs every peak of a newly published spectrogram frame with the peaks of the last HIST
// accepted frames and streams one {anchor_freq, target_freq, dt} hash per qualifying pair.
module peak_pair_hasher #(
  parameter int PEAKS    = 6,
  parameter int AMPL_W   = 8,
  parameter int FREQ_W   = 9,
  parameter int TIME_W   = 16,
  parameter int HIST     = 3,
  parameter int MIN_AMPL = 1,
  parameter int DT_W     = $clog2(HIST + 1)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic                      valid_in,
  input  logic [PEAKS*AMPL_W-1:0]   amplitudes_in,
  input  logic [PEAKS*FREQ_W-1:0]   freqs_in,
  input  logic [TIME_W-1:0]         counter_in,
  peak_pair_hasher_if.master        hash_if,
  output logic                      busy,
  output logic                      overrun
);
  localparam int H_W  = (HIST > 1) ? $clog2(HIST) : 1;
  localparam int S_W  = H_W + 1;
  localparam int P_W  = (PEAKS > 1) ? $clog2(PEAKS) : 1;
  localparam int HD_W = 2*FREQ_W + DT_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Signed amplitude test; the explicit > 0 keeps silent bands out even if MIN_AMPL <= 0.
  function automatic logic peak_qual(input logic [AMPL_W-1:0] amp);
    logic signed [31:0] amp_ext;
    amp_ext = 32'(signed'(amp));
    return (amp_ext >= 32'(MIN_AMPL)) && (amp_ext > 32'sd0);
  endfunction

  logic [2:0]                             sync_q, sync_d;
  logic [1:0]                             state_q, state_d;
  logic [H_W-1:0]                         h_q, h_d, wr_ptr_q, wr_ptr_d;
  logic [P_W-1:0]                         a_q, a_d, t_q, t_d;
  logic [PEAKS-1:0][FREQ_W-1:0]           tgt_freq_q, tgt_freq_d;
  logic [PEAKS-1:0]                       tgt_qual_q, tgt_qual_d;
  logic [TIME_W-1:0]                      tgt_time_q, tgt_time_d;
  logic [HIST-1:0][PEAKS-1:0][FREQ_W-1:0] hist_freq_q, hist_freq_d;
  logic [HIST-1:0][PEAKS-1:0]             hist_qual_q, hist_qual_d;
  logic [HIST-1:0][TIME_W-1:0]            hist_time_q, hist_time_d;
  logic [HIST-1:0]                        hist_vld_q, hist_vld_d;
  logic                                   hv_q, hv_d;
  logic [HD_W-1:0]                        hd_q, hd_d;
  logic [TIME_W-1:0]                      ht_q, ht_d;
  logic                                   busy_q, busy_d;
  logic                                   overrun_q, overrun_d;

  logic [S_W-1:0]    slot_sum_s;
  logic [H_W-1:0]    slot_s;
  logic [TIME_W-1:0] dt_full_s;
  logic              pair_ok_s;
  logic              last_s;
  logic              frame_evt_s;
  logic              out_free_s;

  // Evaluate the pair under the iterator; h counts back from the newest history slot.
  always_comb begin
    slot_sum_s = {1'b0, wr_ptr_q} + S_W'(HIST - 1) - {1'b0, h_q};
    if (slot_sum_s >= S_W'(HIST)) begin
      slot_s = H_W'(slot_sum_s - S_W'(HIST));
    end else begin
      slot_s = slot_sum_s[H_W-1:0];
    end
    // Modular difference, so counter wrap still yields the true frame distance.
    dt_full_s   = tgt_time_q - hist_time_q[slot_s];
    pair_ok_s   = hist_vld_q[slot_s] && hist_qual_q[slot_s][a_q] && tgt_qual_q[t_q] &&
                  (dt_full_s != {TIME_W{1'b0}}) && (dt_full_s <= TIME_W'(HIST));
    last_s      = (h_q == H_W'(HIST - 1)) && (a_q == P_W'(PEAKS - 1)) && (t_q == P_W'(PEAKS - 1));
    frame_evt_s = sync_q[1] & ~sync_q[2];
    out_free_s  = ~hv_q | hash_if.hash_ready;
  end

  // Next-state logic: strobe synchronizer, frame FSM, pair iterator, history and output stage.
  always_comb begin
    sync_d      = {sync_q[1:0], valid_in};
    state_d     = state_q;
    h_d         = h_q;
    a_d         = a_q;
    t_d         = t_q;
    wr_ptr_d    = wr_ptr_q;
    tgt_freq_d  = tgt_freq_q;
    tgt_qual_d  = tgt_qual_q;
    tgt_time_d  = tgt_time_q;
    hist_freq_d = hist_freq_q;
    hist_qual_d = hist_qual_q;
    hist_time_d = hist_time_q;
    hist_vld_d  = hist_vld_q;
    hd_d        = hd_q;
    ht_d        = ht_q;
    if (out_free_s) begin
      hv_d = 1'b0;
    end else begin
      hv_d = hv_q;
    end
    if (frame_evt_s && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_evt_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        for (int p = 0; p < PEAKS; p++) begin
          tgt_freq_d[p] = freqs_in[p*FREQ_W +: FREQ_W];
          tgt_qual_d[p] = peak_qual(amplitudes_in[p*AMPL_W +: AMPL_W]);
        end
        tgt_time_d = counter_in;
        h_d        = {H_W{1'b0}};
        a_d        = {P_W{1'b0}};
        t_d        = {P_W{1'b0}};
        state_d    = ST_EMIT;
      end
      ST_EMIT: begin
        // The iterator only moves when the output register is empty or being taken.
        if (out_free_s) begin
          hv_d = pair_ok_s;
          if (pair_ok_s) begin
            hd_d = {hist_freq_q[slot_s][a_q], tgt_freq_q[t_q], dt_full_s[DT_W-1:0]};
            ht_d = hist_time_q[slot_s];
          end else begin
            hd_d = hd_q;
            ht_d = ht_q;
          end
          if (last_s) begin
            state_d = ST_COMMIT;
          end else if (t_q == P_W'(PEAKS - 1)) begin
            t_d = {P_W{1'b0}};
            if (a_q == P_W'(PEAKS - 1)) begin
              a_d = {P_W{1'b0}};
              h_d = h_q + H_W'(1);
            end else begin
              a_d = a_q + P_W'(1);
            end
          end else begin
            t_d = t_q + P_W'(1);
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_COMMIT: begin
        hist_freq_d[wr_ptr_q] = tgt_freq_q;
        hist_qual_d[wr_ptr_q] = tgt_qual_q;
        hist_time_d[wr_ptr_q] = tgt_time_q;
        hist_vld_d[wr_ptr_q]  = 1'b1;
        if (wr_ptr_q == H_W'(HIST - 1)) begin
          wr_ptr_d = {H_W{1'b0}};
        end else begin
          wr_ptr_d = wr_ptr_q + H_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers; reset abandons any frame in flight and empties the history.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 3'b000;
      state_q     <= ST_IDLE;
      h_q         <= {H_W{1'b0}};
      a_q         <= {P_W{1'b0}};
      t_q         <= {P_W{1'b0}};
      wr_ptr_q    <= {H_W{1'b0}};
      tgt_freq_q  <= {(PEAKS*FREQ_W){1'b0}};
      tgt_qual_q  <= {PEAKS{1'b0}};
      tgt_time_q  <= {TIME_W{1'b0}};
      hist_freq_q <= {(HIST*PEAKS*FREQ_W){1'b0}};
      hist_qual_q <= {(HIST*PEAKS){1'b0}};
      hist_time_q <= {(HIST*TIME_W){1'b0}};
      hist_vld_q  <= {HIST{1'b0}};
      hv_q        <= 1'b0;
      hd_q        <= {HD_W{1'b0}};
      ht_q        <= {TIME_W{1'b0}};
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      h_q         <= h_d;
      a_q         <= a_d;
      t_q         <= t_d;
      wr_ptr_q    <= wr_ptr_d;
      tgt_freq_q  <= tgt_freq_d;
      tgt_qual_q  <= tgt_qual_d;
      tgt_time_q  <= tgt_time_d;
      hist_freq_q <= hist_freq_d;
      hist_qual_q <= hist_qual_d;
      hist_time_q <= hist_time_d;
      hist_vld_q  <= hist_vld_d;
      hv_q        <= hv_d;
      hd_q        <= hd_d;
      ht_q        <= ht_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign hash_if.hash_valid = hv_q;
  assign hash_if.hash_data  = hd_q;
  assign hash_if.hash_time  = ht_q;
  assign busy               = busy_q;
  assign overrun            = overrun_q;
endmodule
